hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, HALT drain sequencing
// and single-step debug gating for a 5-stage pipeline.
module hazard_ctrl #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter int         DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_idex_memRead,
    input  logic [4:0] i_idex_rt,
    input  logic [4:0] i_ifid_rs,
    input  logic [4:0] i_ifid_rt,
    input  logic [5:0] i_ifid_opcode,
    input  logic       i_branch_taken,
    input  logic       i_debug_mode,
    input  logic       i_step,
    output logic       o_pc_write,
    output logic       o_ifid_write,
    output logic       o_ifid_flush,
    output logic       o_stall,
    output logic       o_halt,
    output logic [1:0] o_state
);

    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = (DRAIN_CYCLES < 1) ? '0 : CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'b00,
        ST_DRAIN     = 2'b01,
        ST_HALTED    = 2'b10,
        ST_STEP_WAIT = 2'b11
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          step_q_r;
    logic          load_use_s;
    logic          step_edge_s;
    logic          halt_req_s;

    // r0 is hard-wired zero, so a load into it can never create a dependency
    assign load_use_s  = i_idex_memRead && (i_idex_rt != 5'd0) &&
                         ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
    assign step_edge_s = i_step && !step_q_r;
    assign halt_req_s  = (i_ifid_opcode == HALT_OPCODE) && !load_use_s;
    assign o_state     = state_r;

    // State, drain counter and step history registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_RUN;
            cnt_r    <= '0;
            step_q_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            step_q_r <= i_step;
        end
    end

    // Next-state and drain counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (halt_req_s) begin
                    state_s = ST_DRAIN;
                    cnt_s   = DRAIN_LOAD;
                end else if (i_debug_mode) begin
                    state_s = ST_STEP_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // counter saturates at zero; zero means the last drain cycle
                if (cnt_r == '0) begin
                    state_s = ST_HALTED;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_HALTED: begin
                state_s = ST_HALTED;
            end
            ST_STEP_WAIT: begin
                if (!i_debug_mode || step_edge_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_STEP_WAIT;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = '0;
            end
        endcase
    end

    // Pipeline control outputs; reset forces the free-running RUN values
    always_comb begin
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_stall      = 1'b0;
        o_halt       = 1'b0;
        if (!i_rst_n) begin
            o_pc_write = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // a stalled branch is re-resolved next cycle, so no flush yet
                    o_stall      = load_use_s;
                    o_pc_write   = !load_use_s;
                    o_ifid_write = !load_use_s;
                    o_ifid_flush = i_branch_taken && !load_use_s;
                end
                ST_DRAIN: begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_stall      = 1'b1;
                end
                ST_HALTED, ST_STEP_WAIT: begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_halt       = 1'b1;
                end
                default: begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_halt       = 1'b1;
                end
            endcase
        end
    end

endmodule
